// File: rtl/maxnet_pkg.sv
// Shared MaxNet types, sizes and the activation clip used at each row write-back.
// Pure declarations; no clocked logic lives here.
package maxnet_pkg;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int FRAC = 6;
  localparam int ACCW = 2*DW + 2;
  localparam int AMAX = 2**(DW-1) - 1;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE, FIN} state_e;

  // Floor-shift back to activation scale, then keep only the non-negative, saturated part.
  function automatic logic signed [DW-1:0] clip_act(input logic signed [ACCW-1:0] sum);
    logic signed [ACCW-1:0] sh;
    sh = sum >>> FRAC;
    if (sh[ACCW-1]) return '0;
    if (sh > ACCW'(AMAX)) return DW'(AMAX);
    return sh[DW-1:0];
  endfunction
endpackage

// File: rtl/maxnet_mac.sv
// Shared signed multiply-accumulate; acc_o already includes the current product.
// Register updates one cycle after en_i; clr_i restarts the running sum from zero.
module maxnet_mac
  import maxnet_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   w_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  output logic signed [ACCW-1:0] acc_o
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_q;

  assign prod  = a_i * w_i;
  assign acc_o = acc_q + ACCW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_o;
  end
endmodule

// File: rtl/maxnet_core.sv
// One MaxNet iteration over four activations with a single MAC: 18 busy cycles from strt to idle.
// Loads and strt are only honoured in IDLE; everything arriving while busy is dropped.
module maxnet_core
  import maxnet_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic [N-1:0]  xe,
  input  logic [N-1:0]  we,
  input  logic          strt,
  output logic          done1,
  output logic          done,
  output logic [2:0]    max
);
  state_e state_q, state_d;
  logic [1:0] i_q, i_d, j_q, j_d;
  logic [1:0] w_idx;
  logic signed [DW-1:0] a_q [N];
  logic signed [DW-1:0] w_q [N];
  logic signed [DW-1:0] nxt_q [N];
  logic signed [ACCW-1:0] mac_acc;
  logic mac_clr, mac_en, nxt_wr, upd, ld_en;
  logic done_q;
  logic [2:0] max_q;
  logic [2:0] pos_cnt;
  logic [1:0] best_idx;
  logic signed [DW-1:0] best_val;

  assign w_idx = j_q - i_q;
  assign ld_en = (state_q == IDLE);
  assign done  = done_q;
  assign max   = max_q;

  maxnet_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (a_q[j_q]),
    .w_i   (w_q[w_idx]),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .acc_o (mac_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    nxt_wr  = 1'b0;
    upd     = 1'b0;
    done1   = 1'b0;
    case (state_q)
      IDLE: if (strt) begin
        state_d = CALC;
        i_d     = '0;
        j_d     = '0;
        mac_clr = 1'b1;
      end
      CALC: begin
        j_d = j_q + 2'd1;
        if (j_q == 2'd3) begin
          // Row complete: capture it and restart the sum for the next row.
          nxt_wr  = 1'b1;
          mac_clr = 1'b1;
          i_d     = i_q + 2'd1;
          if (i_q == 2'd3) state_d = UPDATE;
        end else begin
          mac_en = 1'b1;
        end
      end
      UPDATE: begin
        upd     = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        done1   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clipped values are never negative, so "positive" is simply non-zero.
  always_comb begin
    pos_cnt  = '0;
    best_idx = '0;
    best_val = nxt_q[0];
    for (int k = 0; k < N; k++) begin
      if (nxt_q[k] != '0) pos_cnt = pos_cnt + 3'd1;
    end
    for (int k = 1; k < N; k++) begin
      if (nxt_q[k] > best_val) begin
        best_val = nxt_q[k];
        best_idx = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      max_q  <= '0;
      for (int k = 0; k < N; k++) begin
        a_q[k]   <= '0;
        w_q[k]   <= '0;
        nxt_q[k] <= '0;
      end
    end else begin
      if (nxt_wr) nxt_q[i_q] <= clip_act(mac_acc);
      if (upd) begin
        a_q    <= nxt_q;
        done_q <= (pos_cnt <= 3'd1);
        max_q  <= {1'b0, best_idx};
      end else if (ld_en) begin
        for (int k = 0; k < N; k++) begin
          if (xe[k]) a_q[k] <= din;
          if (we[k]) w_q[k] <= din;
        end
        if (|xe) done_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/maxnet_core.md
# maxnet_core

Compute engine answering the inference controller's start/done handshake. It holds four signed activations and four signed weights, loaded one word at a time from the controller's memory fetch sequence. On each `strt` pulse it runs one MaxNet iteration with a single shared multiply-accumulate, pulses `done1` and reports `done` plus the winner index `max`. The controller then reads that index back from memory.

## Interface
- `DW`, 8: activation/weight width, two's complement.
- `FRAC`, 6: weight fraction bits (Q1.6; 64 = 1.0).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `din`  in  DW  memory read data, sampled with any enable.
- `xe`  in  4  activation write enables; `xe[k]` loads `a[k] <= din`.
- `we`  in  4  weight write enables; `we[k]` loads `W[k] <= din`.
- `strt`  in  1  one-cycle start of one iteration.
- `done1`  out  1  one-cycle pulse: iteration finished.
- `done`  out  1  level: at most one activation is positive.
- `max`  out  3  index (0..3, MSB always 0) of the largest activation.

## Operation
- Iteration: `a_i' = clip( (sum_j W[(j-i) mod 4] * a_j) >>> FRAC )` for i = 0..3.
  - `W[0]` is the self weight; `W[1..3]` are the circulant inhibition weights.
  - `>>>` is an arithmetic shift, so it floors.
  - `clip` forces negatives to 0 and saturates at `2^(DW-1)-1`.
- Accumulator: signed `2*DW+2` bits, so no overflow is possible.
- Loads:
  - `xe`/`we` are honoured only in IDLE and ignored while busy.
  - Multiple enable bits in one cycle all load the same `din`.
  - Any `xe` bit clears `done`.
- States:
  - IDLE: on `strt`, go to CALC with i=0, j=0, acc=0.
  - CALC: one MAC per cycle, `acc += W[(j-i)&3]*a[j]`.
    - At j=3, the clipped result goes to shadow register `nxt[i]`, acc resets, j wraps to 0 and i increments.
    - After i=3, j=3, go to UPDATE.
  - UPDATE: `a <= nxt` (all four at once); count positives of `nxt`; `done <= (count<=1)`; `max <=` index of the largest `nxt`, lowest index on a tie. Go to FIN.
  - FIN: `done1=1`; go to IDLE.
- `strt` outside IDLE is ignored, not queued.
- `strt` together with `xe`/`we` in IDLE: the loads take effect first and the iteration uses the new values.
- Reset values:
  - `done1`=0, `done`=0, `max`=0.
  - All `a`, `W` and `nxt` = 0; acc=0; state IDLE.
  - Reset mid-iteration aborts with no `done1` and no partial write-back.

## Timing
- `strt` is sampled high at edge T0.
- CALC spans edges T1..T16.
- UPDATE is sampled at T17; `a`, `done` and `max` are visible after T17.
- `done1` is high for exactly the cycle between T17 and T18.
- A new `strt` is accepted at T18 or later.
- Back-to-back: the controller's START→WAIT→check→START loop needs ≥3 cycles; every iteration is 18 cycles of busy time.
- `done`/`max` are stable between iterations and change only in UPDATE, or when `done` is cleared by `xe`.

## Structure
- Shared package `maxnet_pkg`:
  - State enum `{IDLE, CALC, UPDATE, FIN}`.
  - Constants `N=4`, `DW`, `FRAC`, `ACCW=2*DW+2`.
  - Function `clip_act`.
- Sub-module `maxnet_mac`:
  - Registered signed multiply-accumulate with clear and enable.
  - Inputs: operands `a`, `w`; controls `clr`, `en`.
  - Output `acc`; it is the only arithmetic path.
- Everything else (counters, register files, argmax, positive count) lives in `maxnet_core`.

## Test plan
- Nominal: load `W`={64,-8,-8,-8}, `x`={40,20,10,5}, pulse `strt` → `done1` at T17/T18, `a`={35,13,1,0}, `done`=0, `max`=0.
- Single winner: `W` as above, `x`={50,0,0,0} → `a`={50,0,0,0}, `done`=1, `max`=0 after one iteration; the next `xe` write clears `done`.
- Tie and identity: `W`={64,0,0,0}, `x`={0,20,20,0} → `a` unchanged, `done`=0, `max`=1.
- Saturation: `W`={127,0,0,0}, `x`={127,0,0,0} → `a0`=127 (the unclipped 252 is clipped), `done`=1.
- Protocol robustness:
  - `strt`, `xe` and `we` pulsed during CALC → ignored; results equal the nominal case.
  - Exactly one `done1` per accepted `strt`.
- Reset mid-op: assert `rst_n`=0 at T8 → all outputs 0 immediately and no `done1`. After release, a full reload and `strt` reproduce the nominal case.
